// File: rtl/flood_engine_if.sv
// rtl/flood_engine_if.sv - selection handshake, board RAM bus and status signals of the flood engine
interface flood_engine_if;
  logic       COLOR_SEL_SIG;
  logic [2:0] COLOR_SELECTED;
  logic [4:0] final_SIZE;
  logic [3:0] MEM_RDATA;
  logic [9:0] MEM_ADDR;
  logic       MEM_WE;
  logic [3:0] MEM_WDATA;
  logic       CURRENTLY_CHANGING_COLOR;
  logic       FLOOD_DONE;
  logic       WON;
  logic [9:0] FLOODED_COUNT;

  modport master (
    input  COLOR_SEL_SIG, COLOR_SELECTED, final_SIZE, MEM_RDATA,
    output MEM_ADDR, MEM_WE, MEM_WDATA, CURRENTLY_CHANGING_COLOR,
           FLOOD_DONE, WON, FLOODED_COUNT
  );

  modport slave (
    output COLOR_SEL_SIG, COLOR_SELECTED, final_SIZE, MEM_RDATA,
    input  MEM_ADDR, MEM_WE, MEM_WDATA, CURRENTLY_CHANGING_COLOR,
           FLOOD_DONE, WON, FLOODED_COUNT
  );
endinterface

// File: rtl/flood_engine.sv
// rtl/flood_engine.sv - one Flood-It move: recolour the flooded region, then grow it by raster sweeps
module flood_engine #(
  parameter int MAX_SIZE = 26
) (
  input logic            MASTER_CLOCK,
  input logic            RESET,
  flood_engine_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, RC_RD, RC_CHK, RC_WR, GR_RD, GR_CHK, NB_RD, NB_CHK, GR_WR, FINISH
  } state_e;

  localparam logic [4:0] MAX_N = 5'(MAX_SIZE);

  state_e     state_q, state_d;
  logic       sel_q;
  logic [2:0] new_q, new_d;
  logic [4:0] n_q, n_d;
  logic [4:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [9:0] count_q, count_d;
  logic       changed_q, changed_d;
  logic [1:0] nb_q, nb_d;
  logic [9:0] cnt_out_q, cnt_out_d;
  logic       won_q, won_d;

  logic       we;
  logic [9:0] addr;
  logic       adv_rc, adv_gr, chg_next;
  logic [9:0] cnt_next;

  // Neighbour order is up, left, down, right; returns {found, index} of the first usable one >= from.
  function automatic logic [2:0] first_nb(input logic [3:0] ok, input logic [2:0] from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (ok[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  logic [4:0] last_idx;
  logic       last_col, last_cell;
  logic [3:0] nb_ok;
  logic [2:0] nb_first, nb_next;
  logic [9:0] n_sq;

  assign last_idx  = n_q - 5'd1;
  assign last_col  = (col_q == last_idx);
  assign last_cell = last_col && (row_q == last_idx);
  assign nb_ok     = {col_q != last_idx, row_q != last_idx, col_q != 5'd0, row_q != 5'd0};
  assign nb_first  = first_nb(nb_ok, 3'd0);
  assign nb_next   = first_nb(nb_ok, {1'b0, nb_q} + 3'd1);
  assign n_sq      = {5'd0, n_q} * {5'd0, n_q};

  // sel_q resets high so a request already asserted when reset releases is not taken as an edge.
  always_ff @(posedge MASTER_CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      sel_q     <= 1'b1;
      new_q     <= '0;
      n_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
      nb_q      <= '0;
      cnt_out_q <= '0;
      won_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= bus.COLOR_SEL_SIG;
      new_q     <= new_d;
      n_q       <= n_d;
      row_q     <= row_d;
      col_q     <= col_d;
      count_q   <= count_d;
      changed_q <= changed_d;
      nb_q      <= nb_d;
      cnt_out_q <= cnt_out_d;
      won_q     <= won_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    new_d     = new_q;
    n_d       = n_q;
    row_d     = row_q;
    col_d     = col_q;
    count_d   = count_q;
    changed_d = changed_q;
    nb_d      = nb_q;
    cnt_out_d = cnt_out_q;
    won_d     = won_q;
    we        = 1'b0;
    adv_rc    = 1'b0;
    adv_gr    = 1'b0;
    cnt_next  = count_q;
    chg_next  = changed_q;

    case (state_q)
      IDLE: begin
        if (bus.COLOR_SEL_SIG && !sel_q) begin
          new_d = bus.COLOR_SELECTED;
          n_d   = bus.final_SIZE;
          row_d = '0;
          col_d = '0;
          if (bus.final_SIZE < 5'd2 || bus.final_SIZE > MAX_N) state_d = FINISH;
          else                                                 state_d = RC_RD;
        end
      end
      RC_RD:  state_d = RC_CHK;
      RC_CHK: begin
        if (bus.MEM_RDATA[3]) state_d = RC_WR;
        else                  adv_rc  = 1'b1;
      end
      RC_WR: begin
        we     = 1'b1;
        adv_rc = 1'b1;
      end
      GR_RD:  state_d = GR_CHK;
      GR_CHK: begin
        if (bus.MEM_RDATA[3]) begin
          cnt_next = count_q + 10'd1;
          adv_gr   = 1'b1;
        end else if (bus.MEM_RDATA[2:0] == new_q && nb_first[2]) begin
          nb_d    = nb_first[1:0];
          state_d = NB_RD;
        end else begin
          adv_gr = 1'b1;
        end
      end
      NB_RD:  state_d = NB_CHK;
      NB_CHK: begin
        if (bus.MEM_RDATA[3]) begin
          state_d = GR_WR;
        end else if (nb_next[2]) begin
          nb_d    = nb_next[1:0];
          state_d = NB_RD;
        end else begin
          adv_gr = 1'b1;
        end
      end
      GR_WR: begin
        we       = 1'b1;
        cnt_next = count_q + 10'd1;
        chg_next = 1'b1;
        adv_gr   = 1'b1;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Raster advance; the last cell either rolls into the next sweep or closes the move.
    if (adv_rc || adv_gr) begin
      if (!last_cell) begin
        col_d     = last_col ? 5'd0 : col_q + 5'd1;
        row_d     = last_col ? row_q + 5'd1 : row_q;
        count_d   = cnt_next;
        changed_d = chg_next;
        state_d   = adv_rc ? RC_RD : GR_RD;
      end else begin
        row_d     = '0;
        col_d     = '0;
        count_d   = '0;
        changed_d = 1'b0;
        if (adv_rc || chg_next) begin
          state_d = GR_RD;
        end else begin
          state_d   = FINISH;
          cnt_out_d = cnt_next;
          won_d     = (cnt_next == n_sq);
        end
      end
    end
  end

  always_comb begin
    addr = {row_q, col_q};
    if (state_q == NB_RD || state_q == NB_CHK) begin
      case (nb_q)
        2'd0:    addr = {row_q - 5'd1, col_q};
        2'd1:    addr = {row_q, col_q - 5'd1};
        2'd2:    addr = {row_q + 5'd1, col_q};
        default: addr = {row_q, col_q + 5'd1};
      endcase
    end else if (state_q == IDLE || state_q == FINISH) begin
      addr = '0;
    end
  end

  assign bus.MEM_ADDR                 = addr;
  assign bus.MEM_WE                   = we;
  assign bus.MEM_WDATA                = we ? {1'b1, new_q} : 4'd0;
  assign bus.CURRENTLY_CHANGING_COLOR = (state_q != IDLE) && (state_q != FINISH);
  assign bus.FLOOD_DONE               = (state_q == FINISH);
  assign bus.WON                      = won_q;
  assign bus.FLOODED_COUNT            = cnt_out_q;

endmodule

// File: tb/tb_flood_engine.sv
// tb/tb_flood_engine.sv - self-checking bench for flood_engine with board RAM model and BFS flood reference
module tb_flood_engine;

  logic clk;
  logic rst;
  flood_engine_if bus ();

  flood_engine #(.MAX_SIZE(26)) dut (
    .MASTER_CLOCK (clk),
    .RESET        (rst),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [3:0] mem [0:1023];
  logic       load_req = 1'b0;
  logic [2:0] ref_col [26][26];
  bit         ref_fl  [26][26];

  int         writes = 0;
  logic       prev_we = 1'b0;
  logic [2:0] cur_colour = 3'd0;

  int         busy_cyc, done_cnt, mv_writes;
  logic [9:0] got_count, exp_count;
  logic       got_won, exp_won;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [9:0] ai(input int r, input int c);
    return {5'(r), 5'(c)};
  endfunction

  always @(posedge clk) begin
    if (load_req) begin
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++)
          mem[ai(r, c)] <= {ref_fl[r][c], ref_col[r][c]};
    end else if (bus.MEM_WE) begin
      mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
    end
    bus.MEM_RDATA <= mem[bus.MEM_ADDR];
  end

  always @(negedge clk) begin
    if (bus.MEM_WE) begin
      check("we_back_to_back", prev_we, 0);
      check("wdata", bus.MEM_WDATA, {1'b1, cur_colour});
      writes <= writes + 1;
    end
    prev_we <= bus.MEM_WE;
  end

  // Reference: recolour the flooded set, then absorb every cell of the new colour reachable from it.
  task automatic model_move(input int n, input logic [2:0] colour, output int cnt);
    int q[$];
    int p, pr, pc, nr, nc;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (ref_fl[r][c]) begin
          ref_col[r][c] = colour;
          q.push_back(r * 32 + c);
        end
    while (q.size() != 0) begin
      p  = q.pop_front();
      pr = p / 32;
      pc = p % 32;
      for (int d = 0; d < 4; d++) begin
        nr = pr + ((d == 0) ? -1 : (d == 2) ? 1 : 0);
        nc = pc + ((d == 1) ? -1 : (d == 3) ? 1 : 0);
        if (nr >= 0 && nr < n && nc >= 0 && nc < n &&
            !ref_fl[nr][nc] && ref_col[nr][nc] == colour) begin
          ref_fl[nr][nc] = 1'b1;
          q.push_back(nr * 32 + nc);
        end
      end
    end
    cnt = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (ref_fl[r][c]) cnt++;
  endtask

  task automatic load_board();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic random_board(input int n);
    int e;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) begin
        ref_fl[r][c]  = 1'b0;
        ref_col[r][c] = 3'($urandom_range(0, 5));
      end
    ref_fl[0][0] = 1'b1;
    model_move(n, ref_col[0][0], e);
    load_board();
  endtask

  // Colour-2 path whose middle row is only reachable from its right end.
  task automatic build_snake();
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) begin
        ref_fl[r][c]  = 1'b0;
        ref_col[r][c] = ((r + c) % 2 == 0) ? 3'd1 : 3'd3;
      end
    for (int c = 1; c < 6; c++) ref_col[0][c] = 3'd2;
    ref_col[1][5] = 3'd2;
    for (int c = 0; c < 6; c++) ref_col[2][c] = 3'd2;
    ref_col[3][0] = 3'd2;
    for (int c = 0; c < 6; c++) ref_col[4][c] = 3'd2;
    ref_col[5][5] = 3'd2;
    ref_col[0][0] = 3'd0;
    ref_fl[0][0]  = 1'b1;
    load_board();
  endtask

  task automatic compare_board(input int n, input string tag);
    int bad;
    bad = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        if (mem[ai(r, c)] !== {ref_fl[r][c], ref_col[r][c]}) bad++;
    check({tag, "_board_bad_cells"}, bad, 0);
  endtask

  task automatic run_move(input logic [2:0] colour, input logic [4:0] size);
    int w0;
    w0         = writes;
    busy_cyc   = 0;
    done_cnt   = 0;
    cur_colour = colour;
    @(negedge clk);
    bus.COLOR_SELECTED = colour;
    bus.final_SIZE     = size;
    bus.COLOR_SEL_SIG  = 1'b1;
    for (int k = 0; k < 60000 && done_cnt == 0; k++) begin
      @(negedge clk);
      if (bus.CURRENTLY_CHANGING_COLOR) begin
        busy_cyc++;
        bus.COLOR_SEL_SIG = 1'b0;
      end
      if (bus.FLOOD_DONE) begin
        done_cnt++;
        got_count = bus.FLOODED_COUNT;
        got_won   = bus.WON;
        bus.COLOR_SEL_SIG = 1'b0;
      end
    end
    @(negedge clk);
    check("done_one_cycle", bus.FLOOD_DONE, 0);
    mv_writes = writes - w0;
  endtask

  task automatic play(input logic [2:0] colour, input int n, input string tag);
    int e;
    model_move(n, colour, e);
    exp_count = 10'(e);
    exp_won   = (e == n * n);
    run_move(colour, 5'(n));
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_count"}, got_count, exp_count);
    check({tag, "_won"}, got_won, exp_won);
    compare_board(n, tag);
  endtask

  initial begin
    int dn, after, e;
    clk = 1'b0;
    rst = 1'b1;
    bus.COLOR_SEL_SIG  = 1'b0;
    bus.COLOR_SELECTED = 3'd0;
    bus.final_SIZE     = 5'd0;
    exp_count = '0;
    exp_won   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", bus.MEM_WE, 0);
    check("rst_addr", bus.MEM_ADDR, 0);
    check("rst_wdata", bus.MEM_WDATA, 0);
    check("rst_busy", bus.CURRENTLY_CHANGING_COLOR, 0);
    check("rst_done", bus.FLOOD_DONE, 0);
    check("rst_won", bus.WON, 0);
    check("rst_count", bus.FLOODED_COUNT, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 2x2 directed board
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) begin
        ref_fl[r][c]  = 1'b0;
        ref_col[r][c] = 3'd0;
      end
    ref_fl[0][0] = 1'b1; ref_col[0][0] = 3'd1;
    ref_col[0][1] = 3'd2; ref_col[1][0] = 3'd2; ref_col[1][1] = 3'd3;
    load_board();
    play(3'd2, 2, "b2_sel2");
    check("b2_sel2_busy", busy_cyc, 31);
    check("b2_sel2_writes", mv_writes, 3);
    check("b2_sel2_count_abs", got_count, 3);
    check("b2_cell01", mem[ai(0, 1)], 4'b1010);
    check("b2_cell11", mem[ai(1, 1)], 4'b0011);
    play(3'd3, 2, "b2_sel3");
    check("b2_sel3_won_abs", got_won, 1);
    check("b2_sel3_count_abs", got_count, 4);
    play(3'd3, 2, "b2_same");
    check("b2_same_writes", mv_writes, 4);
    check("b2_same_busy", busy_cyc, 20);

    // Snake board needing several sweeps
    build_snake();
    play(3'd2, 6, "snake");
    check("snake_count_abs", got_count, 21);

    // Reset in the middle of the grow sweeps
    build_snake();
    cur_colour = 3'd2;
    @(negedge clk);
    bus.COLOR_SELECTED = 3'd2;
    bus.final_SIZE     = 5'd6;
    bus.COLOR_SEL_SIG  = 1'b1;
    repeat (120) begin
      @(negedge clk);
      if (bus.CURRENTLY_CHANGING_COLOR) bus.COLOR_SEL_SIG = 1'b0;
    end
    check("mid_busy_before_rst", bus.CURRENTLY_CHANGING_COLOR, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.CURRENTLY_CHANGING_COLOR, 0);
    check("mid_rst_we", bus.MEM_WE, 0);
    check("mid_rst_addr", bus.MEM_ADDR, 0);
    check("mid_rst_count", bus.FLOODED_COUNT, 0);
    check("mid_rst_won", bus.WON, 0);
    check("mid_rst_done", bus.FLOOD_DONE, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    exp_won   = 1'b0;
    build_snake();
    play(3'd2, 6, "post_rst");
    check("post_rst_count_abs", got_count, 21);

    // Request held high, plus a second edge while busy
    random_board(5);
    model_move(5, 3'd4, e);
    exp_count  = 10'(e);
    exp_won    = (e == 25);
    cur_colour = 3'd4;
    dn = 0;
    after = 0;
    @(negedge clk);
    bus.COLOR_SELECTED = 3'd4;
    bus.final_SIZE     = 5'd5;
    bus.COLOR_SEL_SIG  = 1'b1;
    for (int k = 0; k < 20000 && after < 30; k++) begin
      @(negedge clk);
      if (k == 5)  bus.COLOR_SEL_SIG = 1'b0;
      if (k == 7)  bus.COLOR_SEL_SIG = 1'b1;
      if (bus.FLOOD_DONE) begin
        dn++;
        got_count = bus.FLOODED_COUNT;
        got_won   = bus.WON;
      end
      if (dn != 0) after++;
    end
    bus.COLOR_SEL_SIG = 1'b0;
    check("held_moves", dn, 1);
    check("held_count", got_count, exp_count);
    check("held_won", got_won, exp_won);
    compare_board(5, "held");
    repeat (2) @(negedge clk);

    // Rejected board sizes leave status untouched and never touch RAM
    run_move(3'd3, 5'd0);
    check("n0_done", done_cnt, 1);
    check("n0_busy", busy_cyc, 0);
    check("n0_writes", mv_writes, 0);
    check("n0_count_kept", got_count, exp_count);
    check("n0_won_kept", got_won, exp_won);
    run_move(3'd1, 5'd27);
    check("n27_done", done_cnt, 1);
    check("n27_writes", mv_writes, 0);
    check("n27_count_kept", got_count, exp_count);

    // Randomised games
    for (int g = 0; g < 5; g++) begin
      int n;
      n = $urandom_range(2, 7);
      random_board(n);
      for (int m = 0; m < 3; m++) play(3'($urandom_range(0, 5)), n, "rand");
    end
    random_board(26);
    play(3'($urandom_range(0, 5)), 26, "max26");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
